// File: rtl/display_pkg.sv
// display_pkg
// Shared constants and types for the multiplexed display scanner.
//   NUM_DIGITS  number of scanned displays
//   SEG_W       segment bus width {G,F,E,D,C,B,A}
//   AN_OFF      digit-enable pattern with every display dark (active-low)
//   scan_state_e  SHOW / BLANK scan states
//   digit_t       digit index (2 bits, values 0..2 legal)
package display_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int SEG_W      = 7;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 3'b111;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_e;

  typedef logic [1:0] digit_t;

  // Round-robin 0->1->2->0; the unreachable code 3 also folds back to 0.
  function automatic digit_t next_digit(input digit_t d);
    return (d >= digit_t'(NUM_DIGITS - 1)) ? digit_t'(0) : d + digit_t'(1);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen
// Up-counting prescaler with a loadable terminal value and synchronous clear.
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   clr_i   synchronous clear (wins over counting)
//   term_i  terminal count value; tc_o is high while the count equals it
//   tc_o    terminal-count flag
module scan_tick_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver
// Time-multiplexes three 7-segment displays onto one segment bus. The 21
// segment inputs are captured once per frame (when display 0 is lit), so a
// display never shows a mix of old and new data.
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   en           scan enable; low = all digits dark and scan restarted
//   A..G         per-segment levels, bit i belongs to display i
//   seg          shared segment bus {G,F,E,D,C,B,A}
//   an           active-low digit enables, at most one low
//   frame_start  one-cycle pulse on the edge a new frame is captured
// Optional feature macro: SCAN_GHOST_BLANK_EN inserts BLANK_CYC dark cycles
// between consecutive digits.
//
//   state | meaning
//   SHOW  | display d is lit for REFRESH_DIV cycles
//   BLANK | all displays dark for BLANK_CYC cycles (macro builds only)
module display_scan_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       A,
  input  logic [2:0]       B,
  input  logic [2:0]       C,
  input  logic [2:0]       D,
  input  logic [2:0]       E,
  input  logic [2:0]       F,
  input  logic [2:0]       G,
  output logic [SEG_W-1:0] seg,
  output logic [2:0]       an,
  output logic             frame_start
);

  localparam int MAX_DIV = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(MAX_DIV);
  localparam logic [CNT_W-1:0] SHOW_TC = CNT_W'(REFRESH_DIV - 1);
`ifdef SCAN_GHOST_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_CYC - 1);
`endif

  scan_state_e state_q, state_d;
  digit_t      d_q, d_d;
  logic        run_q, run_d;   // low until the first capture after reset/enable
  logic [SEG_W-1:0][NUM_DIGITS-1:0] frame_q, frame_d, frame_in;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, lit_oh;
  logic                  fs_q, capture;
  logic                  clr, tc;
  logic [CNT_W-1:0]      term;

  assign frame_in = {G, F, E, D, C, B, A};

`ifdef SCAN_GHOST_BLANK_EN
  assign term = (state_q == BLANK) ? BLANK_TC : SHOW_TC;
`else
  assign term = SHOW_TC;
`endif

  scan_tick_gen #(.CNT_W(CNT_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .term_i (term),
    .tc_o   (tc)
  );

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    run_d   = run_q;
    clr     = 1'b0;
    capture = 1'b0;
    if (!en) begin
      state_d = SHOW;
      d_d     = '0;
      run_d   = 1'b0;
      clr     = 1'b1;
    end else if (!run_q) begin
      run_d   = 1'b1;
      state_d = SHOW;
      d_d     = '0;
      clr     = 1'b1;
      capture = 1'b1;
    end else if (d_q >= digit_t'(NUM_DIGITS)) begin
      state_d = SHOW;
      d_d     = '0;
      clr     = 1'b1;
      capture = 1'b1;
    end else if (tc) begin
      clr = 1'b1;
`ifdef SCAN_GHOST_BLANK_EN
      if (state_q == SHOW) begin
        state_d = BLANK;
      end else begin
        state_d = SHOW;
        d_d     = next_digit(d_q);
        capture = (d_d == '0);
      end
`else
      d_d     = next_digit(d_q);
      capture = (d_d == '0);
`endif
    end

    frame_d = capture ? frame_in : frame_q;

    // Outputs decode the next state so they move on the same edge as d/state.
    lit_oh = '0;
    an_d   = AN_OFF;
    seg_d  = '0;
    if (run_d && state_d == SHOW) begin
      lit_oh = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << d_d;
      an_d   = ~lit_oh;
      for (int s = 0; s < SEG_W; s++) seg_d[s] = frame_d[s][d_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW;
      d_q     <= '0;
      run_q   <= 1'b0;
      frame_q <= '0;
      seg_q   <= '0;
      an_q    <= AN_OFF;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      run_q   <= run_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fs_q    <= capture;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_driver.sv
module tb_display_scan_driver;

  localparam int RD = 4;
  localparam int BC = 2;
`ifdef SCAN_GHOST_BLANK_EN
  localparam int BK = BC;
`else
  localparam int BK = 0;
`endif
  localparam int P = 3 * (RD + BK);

  typedef struct packed {
    logic [2:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [2:0] A = '0, B = '0, C = '0, D = '0, E = '0, F = '0, G = '0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_start;

  always #5 clk = ~clk;

  display_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .en(en),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
    .seg(seg), .an(an), .frame_start(frame_start)
  );

  task automatic set_in(input logic [2:0] v);
    A = v; B = v; C = v; D = v; E = v; F = v; G = v;
  endtask

  task automatic push_dark(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.an = 3'b111; e.seg = 7'h00; e.fs = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic push_lit(input int dg, input logic [2:0] v, input logic fs);
    exp_t e;
    e.an     = 3'b111;
    e.an[dg] = 1'b0;
    e.seg    = v[dg] ? 7'h7F : 7'h00;
    e.fs     = fs;
    q.push_back(e);
  endtask

  task automatic push_frame(input logic [2:0] v);
    for (int dg = 0; dg < 3; dg++) begin
      for (int k = 0; k < RD; k++) push_lit(dg, v, (dg == 0) && (k == 0));
      push_dark(BK);
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("an", {4'b0, an}, {4'b0, e.an});
      chk("seg", seg, e.seg);
      chk("frame_start", {6'b0, frame_start}, {6'b0, e.fs});
      chk("an_onehot", 7'($countones(~an) <= 1), 7'd1);
    end
  endtask

  initial begin
    // reset held 3 cycles, everything dark
    rst = 1'b1; en = 1'b1; set_in(3'b000);
    push_dark(3);
    run(3);

    // first capture right after release, one full frame plus the next frame start
    rst = 1'b0; set_in(3'b101);
    push_frame(3'b101);
    push_lit(0, 3'b101, 1'b1);
    run(q.size());

    // inputs change while display 1 is lit: no effect until next capture
    rst = 1'b1;
    push_dark(1);
    run(1);
    rst = 1'b0; set_in(3'b000);
    push_frame(3'b000);
    push_frame(3'b111);
    run(RD + BK + 1);
    set_in(3'b111);
    run(q.size());

    // en dropped while display 2 is lit, then re-enabled with new data
    for (int k = 0; k < RD; k++) push_lit(0, 3'b111, k == 0);
    push_dark(BK);
    for (int k = 0; k < RD; k++) push_lit(1, 3'b111, 1'b0);
    push_dark(BK);
    push_lit(2, 3'b111, 1'b0);
    push_lit(2, 3'b111, 1'b0);
    run(q.size());
    en = 1'b0;
    push_dark(2);
    run(2);
    set_in(3'b010); en = 1'b1;
    push_frame(3'b010);
    push_lit(0, 3'b010, 1'b1);
    run(q.size());

    // rst on the terminal-count edge of digit 0: no advance, restart at d=0
    for (int k = 1; k < RD; k++) push_lit(0, 3'b010, 1'b0);
    run(q.size());
    rst = 1'b1;
    push_dark(1);
    run(1);
    rst = 1'b0;
    push_frame(3'b010);
    push_lit(0, 3'b010, 1'b1);
    run(q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Time-multiplexed display driver sitting directly downstream of the octal/hex segment converter. It takes the 21 per-display segment lines (seven segments × three displays) and drives one shared 7-bit segment bus plus three digit enables. The digits are scanned round-robin at a programmable refresh rate. Segment data is captured once per frame so a display never shows a mix of old and new values within one scan.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit (50 MHz → 1 kHz per digit); legal range ≥ 2.
- `BLANK_CYC`, default 500: cycles with all digits off between digits; only used when blanking is compiled in; legal range ≥ 1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  scan enable; low freezes the scan with all digits off.
- `A`,`B`,`C`,`D`,`E`,`F`,`G`  in  3 each  segment level per display; bit i belongs to display i; polarity is passed through unchanged.
- `seg`  out  7  shared segment bus `{G,F,E,D,C,B,A}` of the active display.
- `an`  out  3  digit enables, active-low, at most one low at a time.
- `frame_start`  out  1  one-cycle pulse when display 0 is lit and a new frame has been captured.

## Operation
- State machine with two states:
  - `SHOW`: display `d` is lit.
  - `BLANK`: all displays dark. Exists only with the macro defined.
- Digit index `d` takes values 0→1→2→0. Any other value is unreachable; if it occurs, `d` is forced to 0.
- Prescaler `cnt` counts 0..`REFRESH_DIV`-1 in `SHOW` and 0..`BLANK_CYC`-1 in `BLANK`. It clears on every state change.
- In `SHOW`:
  - `an = ~(3'b001 << d)`.
  - `seg` = captured bit `d` of G..A.
  - When `cnt` reaches its terminal value, go to `BLANK`. Without blanking, advance `d` and stay in `SHOW`.
- At the end of `BLANK`: advance `d`, return to `SHOW`.
- Frame capture: the 21 input bits are registered into `frame` on the edge that enters `SHOW` with `d = 0`. This includes the first entry after reset and the first entry after `en` rises. `frame_start` pulses on that same edge.
- `en` low:
  - `an = 3'b111`, `seg = 0`.
  - `cnt`, `d` and state are reset to `SHOW`, `d = 0`, `cnt = 0`.
  - Scanning resumes with a fresh capture on the first cycle `en` is seen high.
- Inputs that change mid-frame have no effect until the next capture.

## Timing
- Reset values:
  - `an = 3'b111`, `seg = 7'b0000000`, `frame_start = 0`.
  - State `SHOW`, `d = 0`, `cnt = 0`, `frame = 0`.
- First capture happens on the first edge with `rst = 0` and `en = 1`.
- All outputs are registered and decoded from next-state. `an`/`seg` change on the same edge as the state/`d` change, never a cycle later.
- Digit period: `REFRESH_DIV` + `BLANK_CYC` cycles with blanking, `REFRESH_DIV` without.
- Frame period: 3 × digit period.
- `rst` mid-scan has priority over `en` and over a terminal count on the same edge. It returns everything to reset values in one cycle.
- `en` falling on a terminal-count edge: `en` wins. No advance, outputs dark.
- Never more than one `an` bit low on any cycle, including across `en` and `rst` transitions.

## Configuration
- `SCAN_GHOST_BLANK_EN` defined: the `BLANK` state is compiled in; `BLANK_CYC` dark cycles separate consecutive digits to suppress ghosting.
- Not defined: no `BLANK` state and `BLANK_CYC` is ignored. `an` switches directly from one digit to the next on the terminal-count edge.

## Structure
- Shared package `display_pkg`:
  - `NUM_DIGITS = 3`, `SEG_W = 7`.
  - `AN_OFF = 3'b111`.
  - Scan-state enum `{SHOW, BLANK}`.
  - Digit-index typedef (2 bits).
- One natural sub-module, `scan_tick_gen`: a loadable prescaler with terminal-count output and synchronous clear, instantiated once.

## Test plan
Bench uses `REFRESH_DIV = 4`, `BLANK_CYC = 2`.
- Reset held 3 cycles → `an = 111`, `seg = 0`, `frame_start = 0` throughout. First cycle after release with `en = 1` → `an = 110`, `frame_start = 1`.
- A..G = `3'b101` each, macro defined → `an` sequence `110`×4, `111`×2, `101`×4, `111`×2, `011`×4, `111`×2. `seg = 7F`, `00`, `7F` on the respective lit digits. Frame period 18 cycles.
- Same stimulus with the macro undefined → `110`, `101`, `011`, 4 cycles each. Frame period 12 cycles.
- Inputs change from `3'b000` to `3'b111` while display 1 is lit → `seg` stays `00` until the next `frame_start`, then `7F`.
- `en` dropped while display 2 is lit → next cycle `an = 111`. On re-enable, display 0 is lit with a fresh capture and `frame_start` pulses.
- `rst` asserted on the same edge as a terminal count → reset values appear, `d = 0`, no advance to the next digit.
